// File: rtl/rr_mux_select_arbiter_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
package rr_mux_select_arbiter_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Last-granted pointer after reset; channel 0 is searched first.
  localparam logic [SEL_W-1:0] RST_LAST = 2'b11;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_select_arbiter_if.sv
// Request/grant bundle between the requesting sources and the arbiter.
interface rr_mux_select_arbiter_if;
  import rr_mux_select_arbiter_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              done;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              timeout;

  // Arbiter side.
  modport master (
    input  req,
    input  done,
    output sel,
    output grant,
    output busy,
    output timeout
  );

  // Requester side.
  modport slave (
    output req,
    output done,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/rr_mux_select_arbiter_pick.sv
// Round-robin pick: first requesting channel after 'last', with wrap-around.
module rr_priority_pick
  import rr_mux_select_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick,
  output logic              any_req
);

  logic [NUM_CH-1:0] rot_s;
  logic [SEL_W-1:0]  idx_s;

  // Rotate so that bit 0 of rot_s is channel (last+1) mod 4.
  always_comb begin
    rot_s = req;
    case (last)
      2'd0:    rot_s = {req[0], req[3:1]};
      2'd1:    rot_s = {req[1:0], req[3:2]};
      2'd2:    rot_s = {req[2:0], req[3]};
      2'd3:    rot_s = req;
      default: rot_s = req;
    endcase
  end

  // Find-first-set on the rotated vector.
  always_comb begin
    idx_s = 2'd0;
    casez (rot_s)
      4'b???1: idx_s = 2'd0;
      4'b??10: idx_s = 2'd1;
      4'b?100: idx_s = 2'd2;
      4'b1000: idx_s = 2'd3;
      default: idx_s = 2'd0;
    endcase
  end

  // Rotate the found index back into channel numbering (mod 4 by truncation).
  assign pick    = idx_s + last + 2'd1;
  assign any_req = |req;

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter producing the select and one-hot grant for a 4:1 mux.
// Every grant is followed by at least one idle cycle and is bounded to
// MAX_HOLD cycles; sel is held across idle so the mux input stays stable.
module rr_mux_select_arbiter
  import rr_mux_select_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  rr_mux_select_arbiter_if.master  bus
);

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [SEL_W-1:0]  last_r, last_nxt_s;
  logic [SEL_W-1:0]  sel_r, sel_nxt_s;
  logic [NUM_CH-1:0] grant_r, grant_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              timeout_r, timeout_nxt_s;

  logic [SEL_W-1:0]  pick_s;
  logic              any_req_s;
  logic              rel_done_s, rel_wd_s, rel_max_s;

  rr_priority_pick u_pick (
    .req     (bus.req),
    .last    (last_r),
    .pick    (pick_s),
    .any_req (any_req_s)
  );

  assign rel_done_s = bus.done;
  assign rel_wd_s   = ~bus.req[sel_r];
  assign rel_max_s  = (cnt_r == CNT_W'(MAX_HOLD - 1));

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    last_nxt_s    = last_r;
    sel_nxt_s     = sel_r;
    grant_nxt_s   = grant_r;
    busy_nxt_s    = busy_r;
    timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = onehot(pick_s);
          sel_nxt_s   = pick_s;
          last_nxt_s  = pick_s;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = '0;
        end else begin
          grant_nxt_s = 4'b0000;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = '0;
        end
      end
      ST_GRANT: begin
        if (rel_done_s || rel_wd_s || rel_max_s) begin
          state_nxt_s   = ST_IDLE;
          grant_nxt_s   = 4'b0000;
          busy_nxt_s    = 1'b0;
          cnt_nxt_s     = '0;
          // Forced release is only flagged when nothing else ended the grant.
          timeout_nxt_s = rel_max_s & ~rel_done_s & ~rel_wd_s;
        end else begin
          cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = 4'b0000;
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      last_r    <= RST_LAST;
      sel_r     <= 2'b00;
      grant_r   <= 4'b0000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      last_r    <= last_nxt_s;
      sel_r     <= sel_nxt_s;
      grant_r   <= grant_nxt_s;
      busy_r    <= busy_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign bus.sel     = sel_r;
  assign bus.grant   = grant_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Directed self-checking bench for rr_mux_select_arbiter.
module tb_rr_mux_select_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_mux_select_arbiter_if bus ();

  rr_mux_select_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check the grant/busy/sel invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    check_val("inv_busy", {31'd0, bus.busy}, {31'd0, (bus.grant != 4'b0000)});
    if (bus.busy) check_val("inv_onehot", {28'd0, bus.grant}, 32'd1 << bus.sel);
    else          check_val("inv_zero", {28'd0, bus.grant}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic t);
    check_val({tag, "_grant"},   {28'd0, bus.grant},   {28'd0, g});
    check_val({tag, "_sel"},     {30'd0, bus.sel},     {30'd0, s});
    check_val({tag, "_busy"},    {31'd0, bus.busy},    {31'd0, b});
    check_val({tag, "_timeout"}, {31'd0, bus.timeout}, {31'd0, t});
  endtask

  initial begin
    int n;
    logic [3:0] exp_g;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // Reset state
    tick();
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single request on ch0, one-cycle latency, then done release
    bus.req = 4'b0001;
    tick();
    check_out("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("t1_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    check_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Restart from reset so rotation begins at ch0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All channels requesting: ch0,ch1,ch2,ch3,ch0 with one idle gap each
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      check_out($sformatf("t2_g%0d", k), exp_g, 2'(k % 4), 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      check_out($sformatf("t2_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      bus.done = 1'b0;
      tick();
    end
    check_out("t2_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    check_out("t2_wd", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();

    // Sole requester ch2 held: 16 grant cycles then a timeout pulse
    bus.req = 4'b0100;
    tick();
    check_out("t3_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.grant != 4'b0000) n++;
      else break;
    end
    check_val("t3_hold_len", n, 32'd16);
    check_out("t3_timeout", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    check_out("t3_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    check_out("t3_wd", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();

    // Timeout on ch1 with ch0 also requesting: ch0 goes next
    bus.req = 4'b0010;
    tick();
    check_out("t4_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.timeout) break;
    end
    check_out("t4_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    check_out("t4_next", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("t4_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();

    // ch2 withdraws mid-grant: release without timeout
    bus.req = 4'b0100;
    tick();
    check_out("t5_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    tick();
    check_out("t5_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    check_out("t5_wd", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();

    // done coinciding with the last allowed cycle: single release, no timeout
    bus.req = 4'b0100;
    tick();
    check_out("t5b_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    repeat (15) tick();
    check_out("t5b_last", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("t5b_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    check_out("t5b_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // done while idle is ignored
    bus.done = 1'b1;
    tick();
    check_out("t6_done_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    bus.done = 1'b0;

    // Reset during a ch3 grant restores pointer so ch0 wins next
    bus.req = 4'b1000;
    tick();
    check_out("t7_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("t7_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    check_out("t7_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("t7_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_select_arbiter.md
Name: rr_mux_select_arbiter

Overview:
- Round-robin arbiter that generates the 2-bit select and one-hot grant for the team's 4:1 multiplexer.
- Sits directly upstream of the mux: `sel` drives the mux select input; the four requesting sources drive the mux data inputs.
- Guarantees a stable select for the whole grant, fair rotation between channels, and a bounded hold time per grant.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..256.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit i = channel i wants the mux.
- done  input  1  the granted channel finishes; sampled only in GRANT.
- sel  output  2  mux select (index of the granted or last-granted channel).
- grant  output  4  one-hot grant; all zero when no channel is granted.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse on a forced release at MAX_HOLD.

Behaviour:
- All outputs are registered. Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, sel=2'b00, grant=4'b0000, busy=0, timeout=0, hold counter=0, last pointer=2'b11 (so channel 0 has first priority).
- States (encoding from the package): IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching (last+1) mod 4, (last+2) mod 4, ... with wrap-around.
  - On the next edge: enter GRANT; grant=onehot(pick), sel=pick, busy=1, last=pick, counter=0.
  - Latency from req sampled high to grant visible is 1 cycle.
  - If req == 0, stay in IDLE. sel holds its previous value (mux input stays stable); grant=0.
- GRANT: counter increments by 1 each cycle. Release when any of the following holds at a clock edge:
  - (a) done=1;
  - (b) req[sel]=0 (requester withdrew);
  - (c) counter == MAX_HOLD-1 (the grant has been held for MAX_HOLD cycles).
- On release:
  - Go to IDLE; grant=0, busy=0, counter=0; sel unchanged.
  - timeout=1 for exactly one cycle only when (c) holds and neither (a) nor (b) holds.
- Mandatory gap: at least one IDLE cycle with grant=0 between consecutive grants, including back-to-back grants to different channels.
- Requests from non-granted channels during GRANT are ignored; their req bits need not stay asserted and are re-evaluated in IDLE.
- Simultaneous (a), (b) and/or (c): a single release, no timeout pulse unless only (c) holds.
- done while in IDLE: ignored.
- A channel released by timeout that still requests is not re-granted while any other channel requests; round-robin moves past it via last.
- Reset asserted mid-GRANT: at the next edge all registers take reset values, including last=3.
- Invariants: grant is always one-hot or zero; grant != 0 iff busy=1; when busy=1, grant == onehot(sel).

Decomposition:
- Shared package:
  - NUM_CH=4, SEL_W=2;
  - state typedef/localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - function or localparam for the reset pointer value (2'b11).
- Sub-module: rr_priority_pick (combinational). Inputs req[3:0] and last[1:0]; outputs pick[1:0] and any_req. It rotates req by last+1, does a find-first-set, and rotates the result back.
- The arbiter top holds only the FSM, counter and output registers.

Test Plan:
- Reset then req=4'b0001 -> after 1 cycle: grant=0001, sel=0, busy=1. With done=1 one cycle later -> next cycle grant=0000, busy=0, sel stays 0.
- req=4'b1111 held constantly, done pulsed each grant -> grants in order ch0, ch1, ch2, ch3, ch0, each separated by exactly one IDLE cycle with grant=0000.
- req=4'b0100 held, done never asserted, MAX_HOLD=16 -> grant=0100 for exactly 16 cycles, then timeout=1 for one cycle with grant=0000. Then re-grant ch2 (only requester).
- Timeout on ch1 with req=4'b0011 held -> next grant goes to ch0 (not ch1); sel=0.
- During ch2 grant, drop req[2] with done=0 -> release next edge, timeout=0. Same cycle with done=1 and counter==MAX_HOLD-1 -> single release, timeout=0.
- Assert rst for one cycle mid-GRANT on ch3 -> next edge: grant=0, sel=0, busy=0. With req=1111 after that, ch0 is granted first.
